// File: rtl/vga_layer_compositor_if.sv
// Bundle of timing, layer pixel and fade-control signals between a VGA
// front end and the final-stage layer compositor.
interface vga_layer_compositor_if #(
    parameter int LAYERS     = 6,
    parameter int COLOR_BITS = 4
);
    logic [10:0]                     hcount;
    logic [10:0]                     vcount;
    logic                            hsync;
    logic                            vsync;
    logic                            hblnk;
    logic                            vblnk;
    logic [3*COLOR_BITS-1:0]         bg_rgb;
    logic [LAYERS*3*COLOR_BITS-1:0]  layer_rgb;
    logic [LAYERS-1:0]               layer_opaque;
    logic [LAYERS-1:0]               layer_en;
    logic                            fade_out;
    logic                            fade_in;
    logic                            hs;
    logic                            vs;
    logic [COLOR_BITS-1:0]           r;
    logic [COLOR_BITS-1:0]           g;
    logic [COLOR_BITS-1:0]           b;
    logic                            fade_busy;
    logic                            frame_tick;

    modport master (
        output hcount, vcount, hsync, vsync, hblnk, vblnk,
        output bg_rgb, layer_rgb, layer_opaque, layer_en, fade_out, fade_in,
        input  hs, vs, r, g, b, fade_busy, frame_tick
    );

    modport slave (
        input  hcount, vcount, hsync, vsync, hblnk, vblnk,
        input  bg_rgb, layer_rgb, layer_opaque, layer_en, fade_out, fade_in,
        output hs, vs, r, g, b, fade_busy, frame_tick
    );
endinterface

// File: rtl/vga_layer_compositor.sv
// Final VGA pixel stage: priority layer select over background, frame-locked
// fade-to-black / fade-in, blanking, and 2-cycle aligned sync outputs.
module vga_layer_compositor #(
    parameter int LAYERS          = 6,
    parameter int COLOR_BITS      = 4,
    parameter int LEVEL_BITS      = 4,
    parameter int FRAMES_PER_STEP = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    vga_layer_compositor_if.slave  bus
);
    localparam int PIX_W  = 3 * COLOR_BITS;
    localparam int PROD_W = COLOR_BITS + LEVEL_BITS + 1;
    localparam int CNT_W  = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [LEVEL_BITS-1:0] LEVEL_MAX = {LEVEL_BITS{1'b1}};
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(FRAMES_PER_STEP - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FADE_OUT = 2'd1,
        ST_BLACK    = 2'd2,
        ST_FADE_IN  = 2'd3
    } state_t;

    // Scale one channel by (level+1)/2^LEVEL_BITS; level 0 is forced black.
    function automatic logic [COLOR_BITS-1:0] fade_chan(
        input logic [COLOR_BITS-1:0] c,
        input logic [LEVEL_BITS-1:0] lvl
    );
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(c) * (PROD_W'(lvl) + PROD_W'(1));
        if (lvl == {LEVEL_BITS{1'b0}}) begin
            fade_chan = {COLOR_BITS{1'b0}};
        end else begin
            fade_chan = prod[LEVEL_BITS +: COLOR_BITS];
        end
    endfunction

    state_t                  state_r, state_s;
    logic [LEVEL_BITS-1:0]   level_r, level_s;
    logic [CNT_W-1:0]        cnt_r, cnt_s;
    logic                    step_s;
    logic [PIX_W-1:0]        winner_s;
    logic [PIX_W-1:0]        s1_rgb_r;
    logic                    s1_hs_r, s1_vs_r, s1_blank_r;
    logic                    vblnk_q_r, tick_r;
    logic [COLOR_BITS-1:0]   r_s, g_s, b_s;

    assign bus.frame_tick = tick_r;

    // Stage-1 winner: later (higher-index) qualifying layers override earlier ones.
    always_comb begin
        winner_s = bus.bg_rgb;
        for (int i = 0; i < LAYERS; i++) begin
            winner_s = (bus.layer_en[i] && bus.layer_opaque[i]) ?
                       bus.layer_rgb[i*PIX_W +: PIX_W] : winner_s;
        end
    end

    // Stage-2 colour: fade by the current level, or black during blanking.
    always_comb begin
        if (s1_blank_r) begin
            r_s = {COLOR_BITS{1'b0}};
            g_s = {COLOR_BITS{1'b0}};
            b_s = {COLOR_BITS{1'b0}};
        end else begin
            r_s = fade_chan(s1_rgb_r[2*COLOR_BITS +: COLOR_BITS], level_r);
            g_s = fade_chan(s1_rgb_r[COLOR_BITS +: COLOR_BITS], level_r);
            b_s = fade_chan(s1_rgb_r[0 +: COLOR_BITS], level_r);
        end
    end

    // Two-stage pixel pipeline plus vblnk rising-edge detector.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_rgb_r   <= {PIX_W{1'b0}};
            s1_hs_r    <= 1'b0;
            s1_vs_r    <= 1'b0;
            s1_blank_r <= 1'b0;
            bus.hs     <= 1'b0;
            bus.vs     <= 1'b0;
            bus.r      <= {COLOR_BITS{1'b0}};
            bus.g      <= {COLOR_BITS{1'b0}};
            bus.b      <= {COLOR_BITS{1'b0}};
            vblnk_q_r  <= 1'b0;
            tick_r     <= 1'b0;
        end else begin
            s1_rgb_r   <= winner_s;
            s1_hs_r    <= bus.hsync;
            s1_vs_r    <= bus.vsync;
            s1_blank_r <= bus.hblnk | bus.vblnk;
            bus.hs     <= s1_hs_r;
            bus.vs     <= s1_vs_r;
            bus.r      <= r_s;
            bus.g      <= g_s;
            bus.b      <= b_s;
            vblnk_q_r  <= bus.vblnk;
            tick_r     <= bus.vblnk & ~vblnk_q_r;
        end
    end

    // Fade FSM next state: direction changes win over a coincident level step.
    always_comb begin
        state_s = state_r;
        level_s = level_r;
        cnt_s   = cnt_r;
        step_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.fade_out) begin
                    state_s = ST_FADE_OUT;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    step_s = 1'b0;
                end
            end
            ST_BLACK: begin
                if (bus.fade_in && !bus.fade_out) begin
                    state_s = ST_FADE_IN;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    step_s = 1'b0;
                end
            end
            ST_FADE_OUT: begin
                if (bus.fade_in && !bus.fade_out) begin
                    state_s = ST_FADE_IN;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    step_s = tick_r;
                end
            end
            ST_FADE_IN: begin
                if (bus.fade_out) begin
                    state_s = ST_FADE_OUT;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    step_s = tick_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                level_s = LEVEL_MAX;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase

        if (step_s) begin
            if (cnt_r == CNT_LAST) begin
                cnt_s = {CNT_W{1'b0}};
                if (state_r == ST_FADE_OUT) begin
                    level_s = level_r - LEVEL_BITS'(1);
                    state_s = (level_r == LEVEL_BITS'(1)) ? ST_BLACK : ST_FADE_OUT;
                end else begin
                    level_s = level_r + LEVEL_BITS'(1);
                    state_s = (level_r == LEVEL_MAX - LEVEL_BITS'(1)) ? ST_IDLE : ST_FADE_IN;
                end
            end else begin
                cnt_s = cnt_r + CNT_W'(1);
            end
        end else begin
            step_s = 1'b0;
        end
    end

    // Fade FSM registers; busy flag registered alongside the state it reflects.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            level_r       <= LEVEL_MAX;
            cnt_r         <= {CNT_W{1'b0}};
            bus.fade_busy <= 1'b0;
        end else begin
            state_r       <= state_s;
            level_r       <= level_s;
            cnt_r         <= cnt_s;
            bus.fade_busy <= (state_s == ST_FADE_OUT) || (state_s == ST_FADE_IN);
        end
    end
endmodule

// File: tb/tb_vga_layer_compositor.sv
// Randomised and directed bench for vga_layer_compositor against a
// cycle-level behavioural model of selection, fading and blanking.
module tb_vga_layer_compositor;
    localparam int L    = 6;
    localparam int CB   = 4;
    localparam int LB   = 4;
    localparam int F    = 2;
    localparam int W    = 3 * CB;
    localparam int LMAX = (1 << LB) - 1;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    vga_layer_compositor_if #(.LAYERS(L), .COLOR_BITS(CB)) bus ();

    vga_layer_compositor #(
        .LAYERS(L), .COLOR_BITS(CB), .LEVEL_BITS(LB), .FRAMES_PER_STEP(F)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] fch(input logic [3:0] c, input int lvl);
        if (lvl == 0) return 4'd0;
        return 4'((int'(c) * (lvl + 1)) / (1 << LB));
    endfunction

    function automatic logic [11:0] fade3(input logic [11:0] c, input int lvl);
        return {fch(c[11:8], lvl), fch(c[7:4], lvl), fch(c[3:0], lvl)};
    endfunction

    // Behavioural model: level/direction, plus what each output must show next.
    int          m_level = LMAX;
    int          m_dir   = 0;
    int          m_cnt   = 0;
    bit          m_valid = 1'b0;
    logic [11:0] p_rgb, exp_rgb;
    logic        p_hs, p_vs, p_blank, m_vbq, m_tick;
    logic        exp_hs, exp_vs, exp_busy;

    always @(posedge clk) begin
        logic        tick_in, fo, fi, found;
        logic [11:0] win;
        fo = bus.fade_out;
        fi = bus.fade_in;
        if (rst) begin
            m_valid = 1'b1;
            m_level = LMAX; m_dir = 0; m_cnt = 0;
            p_rgb = 12'h000; p_hs = 1'b0; p_vs = 1'b0; p_blank = 1'b0;
            m_vbq = 1'b0; m_tick = 1'b0;
            exp_rgb = 12'h000; exp_hs = 1'b0; exp_vs = 1'b0; exp_busy = 1'b0;
        end else begin
            exp_hs  = p_hs;
            exp_vs  = p_vs;
            exp_rgb = p_blank ? 12'h000 : fade3(p_rgb, m_level);
            tick_in = m_tick;
            m_tick  = bus.vblnk & ~m_vbq;
            m_vbq   = bus.vblnk;
            if (fo && (m_dir == 1 || (m_dir == 0 && m_level == LMAX))) begin
                m_dir = -1; m_cnt = 0;
            end else if (fi && !fo && (m_dir == -1 || (m_dir == 0 && m_level == 0))) begin
                m_dir = 1; m_cnt = 0;
            end else if (tick_in && m_dir != 0) begin
                m_cnt++;
                if (m_cnt == F) begin
                    m_cnt = 0;
                    m_level += m_dir;
                    if (m_level == 0 || m_level == LMAX) m_dir = 0;
                end
            end
            exp_busy = (m_dir != 0);
            win   = bus.bg_rgb;
            found = 1'b0;
            for (int i = L - 1; i >= 0; i--) begin
                if (!found && bus.layer_en[i] && bus.layer_opaque[i]) begin
                    win   = bus.layer_rgb[i*W +: W];
                    found = 1'b1;
                end
            end
            p_rgb   = win;
            p_hs    = bus.hsync;
            p_vs    = bus.vsync;
            p_blank = bus.hblnk | bus.vblnk;
        end
    end

    // Every-cycle comparison of DUT outputs with the model.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_rgb",  {bus.r, bus.g, bus.b}, exp_rgb);
            chk("model_hs",   bus.hs, exp_hs);
            chk("model_vs",   bus.vs, exp_vs);
            chk("model_tick", bus.frame_tick, m_tick);
            chk("model_busy", bus.fade_busy, exp_busy);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.hcount = bus.hcount + 11'd1;
            bus.vcount = bus.vcount + 11'd1;
        end
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            bus.vblnk = 1'b1;
            cyc(3);
            bus.vblnk = 1'b0;
            cyc(3);
        end
    endtask

    task automatic pulse(input logic fo, input logic fi);
        bus.fade_out = fo;
        bus.fade_in  = fi;
        cyc(1);
        bus.fade_out = 1'b0;
        bus.fade_in  = 1'b0;
    endtask

    int tick_count;

    initial begin
        rst = 1'b1;
        bus.hcount = 11'd0; bus.vcount = 11'd0;
        bus.hsync = 1'b0; bus.vsync = 1'b0; bus.hblnk = 1'b0; bus.vblnk = 1'b0;
        bus.bg_rgb = 12'h000; bus.layer_rgb = '0;
        bus.layer_opaque = 6'd0; bus.layer_en = 6'd0;
        bus.fade_out = 1'b0; bus.fade_in = 1'b0;
        cyc(3);
        chk("reset_rgb",  {bus.r, bus.g, bus.b}, 12'h000);
        chk("reset_hs",   bus.hs, 1'b0);
        chk("reset_busy", bus.fade_busy, 1'b0);
        chk("reset_tick", bus.frame_tick, 1'b0);
        rst = 1'b0;

        bus.layer_en = 6'b111111;
        bus.layer_opaque = 6'b001010;
        bus.layer_rgb[1*W +: W] = 12'h0F0;
        bus.layer_rgb[3*W +: W] = 12'hF00;
        bus.bg_rgb = 12'h00F;
        cyc(2);
        chk("priority", {bus.r, bus.g, bus.b}, 12'hF00);
        bus.layer_en = 6'b000010;
        cyc(2);
        chk("mask", {bus.r, bus.g, bus.b}, 12'h0F0);
        bus.layer_en = 6'b111111;
        bus.layer_opaque = 6'd0;
        cyc(2);
        chk("transparent", {bus.r, bus.g, bus.b}, 12'h00F);

        bus.hblnk = 1'b1; bus.hsync = 1'b1;
        cyc(2);
        chk("blank_rgb", {bus.r, bus.g, bus.b}, 12'h000);
        chk("blank_hs", bus.hs, 1'b1);
        bus.hsync = 1'b0; bus.vsync = 1'b1;
        cyc(1);
        chk("hs_delay_hold", bus.hs, 1'b1);
        cyc(1);
        chk("hs_delay_fall", bus.hs, 1'b0);
        chk("vs_delay_rise", bus.vs, 1'b1);
        bus.hblnk = 1'b0; bus.vsync = 1'b0;

        bus.layer_en = 6'd0; bus.bg_rgb = 12'hFFF;
        cyc(2);
        chk("full_white", {bus.r, bus.g, bus.b}, 12'hFFF);
        pulse(1'b1, 1'b0);
        chk("fade_out_busy", bus.fade_busy, 1'b1);
        frames(2);
        chk("level14", {bus.r, bus.g, bus.b}, 12'hEEE);
        frames(14);
        chk("level7", {bus.r, bus.g, bus.b}, 12'h777);
        frames(14);
        chk("black_rgb", {bus.r, bus.g, bus.b}, 12'h000);
        chk("black_busy", bus.fade_busy, 1'b0);

        pulse(1'b0, 1'b1);
        chk("fade_in_busy", bus.fade_busy, 1'b1);
        frames(30);
        chk("fade_in_done", {bus.r, bus.g, bus.b}, 12'hFFF);
        chk("fade_in_idle", bus.fade_busy, 1'b0);

        pulse(1'b1, 1'b0);
        frames(10);
        chk("level10", {bus.r, bus.g, bus.b}, 12'hAAA);
        pulse(1'b0, 1'b1);
        chk("reverse_busy", bus.fade_busy, 1'b1);
        frames(2);
        chk("level11", {bus.r, bus.g, bus.b}, 12'hBBB);
        frames(8);
        chk("reverse_idle_rgb", {bus.r, bus.g, bus.b}, 12'hFFF);
        chk("reverse_idle_busy", bus.fade_busy, 1'b0);

        pulse(1'b1, 1'b1);
        chk("both_busy", bus.fade_busy, 1'b1);
        frames(2);
        chk("both_is_out", {bus.r, bus.g, bus.b}, 12'hEEE);
        frames(18);
        chk("level5", {bus.r, bus.g, bus.b}, 12'h555);

        rst = 1'b1;
        bus.bg_rgb = 12'hABC;
        cyc(1);
        chk("midrst_busy", bus.fade_busy, 1'b0);
        chk("midrst_rgb", {bus.r, bus.g, bus.b}, 12'h000);
        rst = 1'b0;
        cyc(2);
        chk("post_rst_abc", {bus.r, bus.g, bus.b}, 12'hABC);

        bus.vblnk = 1'b1;
        cyc(1);
        chk("tick_rise", bus.frame_tick, 1'b1);
        cyc(1);
        chk("tick_single", bus.frame_tick, 1'b0);
        tick_count = 0;
        repeat (998) begin
            cyc(1);
            tick_count += int'(bus.frame_tick);
        end
        bus.vblnk = 1'b0;
        repeat (5) begin
            cyc(1);
            tick_count += int'(bus.frame_tick);
        end
        chk("tick_extra", tick_count, 0);

        repeat (400) begin
            bus.bg_rgb       = 12'($urandom);
            bus.layer_rgb    = {$urandom, $urandom, $urandom};
            bus.layer_opaque = 6'($urandom);
            bus.layer_en     = 6'($urandom);
            bus.hsync        = 1'($urandom);
            bus.vsync        = 1'($urandom);
            bus.hblnk        = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) bus.vblnk = ~bus.vblnk;
            bus.fade_out     = ($urandom_range(0, 29) == 0);
            bus.fade_in      = ($urandom_range(0, 29) == 0);
            cyc(1);
        end
        bus.fade_out = 1'b0; bus.fade_in = 1'b0;
        cyc(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
